rob_commit_ctrl: RTL

ROB_COMMIT_CTRL -- requirements
Module: rob_commit_ctrl

---
 rtl/rob_pkg.sv | 18 +
 rtl/rob_commit_ctrl_if.sv | 32 +++
 rtl/rob_ptr_ctr.sv | 31 +++
 rtl/rob_commit_ctrl.sv | 90 +++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared types and constants for the ROB commit controller
package rob_pkg;

    localparam int ROB_DEPTH = 64;
    localparam int IDX_W     = $clog2(ROB_DEPTH);

    typedef logic [IDX_W:0] rob_ptr_t;

    typedef enum logic {
        RUN      = 1'b0,
        RECOVER  = 1'b1
    } rob_state_e;

    function automatic logic [1:0] popcnt2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/rob_commit_ctrl_if.sv
// rtl/rob_commit_ctrl_if.sv - dispatch/commit/flush signal bundle between core and ROB controller
interface rob_commit_ctrl_if #(
    parameter int ROB_DEPTH = 64,
    parameter int IDX_W     = $clog2(ROB_DEPTH)
);
    logic [1:0]       disp_valid;
    logic             disp_ready;
    logic [IDX_W-1:0] alloc_idx0;
    logic [IDX_W-1:0] alloc_idx1;
    logic [IDX_W-1:0] head_idx;
    logic [1:0]       head_complete;
    logic [1:0]       head_exception;
    logic [1:0]       commit_valid;
    logic [IDX_W-1:0] commit_idx0;
    logic [IDX_W-1:0] commit_idx1;
    logic             ext_flush;
    logic             exc_flush;
    logic             redirect_ack;
    logic [IDX_W:0]   rob_count;

    modport master (
        output disp_valid, head_complete, head_exception, ext_flush, redirect_ack,
        input  disp_ready, alloc_idx0, alloc_idx1, head_idx, commit_valid,
               commit_idx0, commit_idx1, exc_flush, rob_count
    );

    modport slave (
        input  disp_valid, head_complete, head_exception, ext_flush, redirect_ack,
        output disp_ready, alloc_idx0, alloc_idx1, head_idx, commit_valid,
               commit_idx0, commit_idx1, exc_flush, rob_count
    );
endinterface

// File: rtl/rob_ptr_ctr.sv
// rtl/rob_ptr_ctr.sv - wrap-bit ROB pointer, advances by 0..2 per cycle, synchronous clear
module rob_ptr_ctr #(
    parameter int IDX_W = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr_i,
    input  logic [1:0]     inc_i,
    output logic [IDX_W:0] ptr_o
);
    logic [IDX_W:0] ptr_q;
    logic [IDX_W:0] ptr_d;

    // Clear outranks increment so a flush wins over same-cycle retire/allocate.
    always_comb begin
        ptr_d = ptr_q + {{(IDX_W-1){1'b0}}, inc_i};
        if (clr_i) begin
            ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;
endmodule

// File: rtl/rob_commit_ctrl.sv
// rtl/rob_commit_ctrl.sv - ROB allocation, in-order dual retire and flush/recover control
module rob_commit_ctrl #(
    parameter int ROB_DEPTH = rob_pkg::ROB_DEPTH,
    parameter int IDX_W     = $clog2(ROB_DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    rob_commit_ctrl_if.slave bus
);
    import rob_pkg::*;

    localparam logic [IDX_W:0]   CNT_DISP_MAX = (IDX_W+1)'(ROB_DEPTH - 2);
    localparam logic [IDX_W:0]   CNT_ONE      = (IDX_W+1)'(1);
    localparam logic [IDX_W:0]   CNT_TWO      = (IDX_W+1)'(2);
    localparam logic [IDX_W-1:0] IDX_ONE      = IDX_W'(1);

    rob_state_e     state_q;
    rob_ptr_t       head_ptr;
    rob_ptr_t       tail_ptr;
    logic [IDX_W:0] count;
    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;

    logic           run;
    logic           head_done0;
    logic           exc_flush;
    logic           cv0;
    logic           cv1;
    logic           disp_ready;
    logic           ext_eff;
    logic           ptr_clr;
    logic [1:0]     alloc_inc;
    logic [1:0]     commit_inc;

    assign count    = tail_ptr - head_ptr;
    assign head_idx = head_ptr[IDX_W-1:0];
    assign tail_idx = tail_ptr[IDX_W-1:0];

    // Everything below is gated by reset so strobes read 0 before the first edge.
    assign run        = !rst && (state_q == RUN);
    assign head_done0 = run && (count >= CNT_ONE) && bus.head_complete[0];
    assign exc_flush  = head_done0 && bus.head_exception[0];
    assign cv0        = head_done0 && !bus.head_exception[0];
    assign cv1        = cv0 && (count >= CNT_TWO) && bus.head_complete[1]
                        && !bus.head_exception[1];
    assign disp_ready = run && (count <= CNT_DISP_MAX) && !bus.ext_flush && !exc_flush;
    assign ext_eff    = run && bus.ext_flush;
    assign ptr_clr    = exc_flush || ext_eff;

    assign alloc_inc  = (disp_ready && bus.disp_valid[0]) ? popcnt2(bus.disp_valid) : 2'd0;
    assign commit_inc = popcnt2({cv1, cv0});

    rob_ptr_ctr #(.IDX_W(IDX_W)) u_head_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (ptr_clr),
        .inc_i (commit_inc),
        .ptr_o (head_ptr)
    );

    rob_ptr_ctr #(.IDX_W(IDX_W)) u_tail_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (ptr_clr),
        .inc_i (alloc_inc),
        .ptr_o (tail_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            case (state_q)
                RUN:     if (exc_flush)        state_q <= RECOVER;
                RECOVER: if (bus.redirect_ack) state_q <= RUN;
                default:                       state_q <= RUN;
            endcase
        end
    end

    assign bus.disp_ready   = disp_ready;
    assign bus.exc_flush    = exc_flush;
    assign bus.commit_valid = {cv1, cv0};
    assign bus.rob_count    = rst ? '0 : count;
    assign bus.alloc_idx0   = rst ? '0 : tail_idx;
    assign bus.alloc_idx1   = rst ? '0 : tail_idx + IDX_ONE;
    assign bus.head_idx     = rst ? '0 : head_idx;
    assign bus.commit_idx0  = rst ? '0 : head_idx;
    assign bus.commit_idx1  = rst ? '0 : head_idx + IDX_ONE;
endmodule
